// File: rtl/uart_receiver.sv
// UART receive stage: 2-flop synchroniser, mid-bit sampling FSM, valid/ready byte output.
// Optional even-parity checking is enabled by defining UART_RX_PARITY_EN.
module uart_receiver #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data,
    output logic                 valid,
    input  logic                 ready,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy
`ifdef UART_RX_PARITY_EN
    ,
    output logic                 parity_err
`endif
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT) + 1;
    localparam int IDX_W = $clog2(DATA_BITS) + 1;

    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'((CLKS_PER_BIT - 1) / 2);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;
    localparam logic [2:0] S_BREAK  = 3'd5;

    logic                 sync1_q, sync2_q;
    logic [2:0]           state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 ferr_q, ferr_d;
    logic                 ovr_q, ovr_d;
    logic                 good_byte;
    logic                 bit_tick;
    logic                 rx_s;
`ifdef UART_RX_PARITY_EN
    logic                 par_q, par_d;
    logic                 perr_q, perr_d;
`endif

    assign rx_s     = sync2_q;
    assign bit_tick = (cnt_q == CNT_LAST);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        shift_d   = shift_q;
        data_d    = data_q;
        valid_d   = valid_q;
        ferr_d    = 1'b0;
        ovr_d     = 1'b0;
        good_byte = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_d     = par_q;
        perr_d    = 1'b0;
`endif

        if (valid_q && ready) begin
            valid_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (!rx_s) begin
                    state_d = S_START;
                    cnt_d   = '0;
                end
            end
            S_START: begin
                // Re-check the line at mid start bit; a high line here was a glitch.
                if (cnt_q == CNT_HALF) begin
                    if (rx_s) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_DATA;
                        cnt_d   = '0;
                        idx_d   = '0;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_DATA: begin
                if (bit_tick) begin
                    cnt_d                = '0;
                    shift_d              = shift_q >> 1;
                    shift_d[DATA_BITS-1] = rx_s;
                    idx_d                = idx_q + IDX_ONE;
                    if (idx_q == IDX_LAST) begin
`ifdef UART_RX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (bit_tick) begin
                    cnt_d   = '0;
                    par_d   = rx_s;
                    state_d = S_STOP;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
`endif
            S_STOP: begin
                if (bit_tick) begin
                    cnt_d = '0;
                    if (rx_s) begin
                        state_d = S_IDLE;
`ifdef UART_RX_PARITY_EN
                        if (^{shift_q, par_q}) begin
                            perr_d = 1'b1;
                        end else begin
                            good_byte = 1'b1;
                        end
`else
                        good_byte = 1'b1;
`endif
                    end else begin
                        // Bad stop bit: drop the byte and wait out a held-low line.
                        ferr_d  = 1'b1;
                        state_d = S_BREAK;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_BREAK: begin
                if (rx_s) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // A slot frees up if the consumer takes the old byte on this same edge.
        if (good_byte) begin
            if (!valid_q || ready) begin
                data_d  = shift_q;
                valid_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_q   <= 1'b0;
            perr_q  <= 1'b0;
`endif
        end else begin
            sync1_q <= rx;
            sync2_q <= sync1_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
`ifdef UART_RX_PARITY_EN
            par_q   <= par_d;
            perr_q  <= perr_d;
`endif
        end
    end

    assign data      = data_q;
    assign valid     = valid_q;
    assign frame_err = ferr_q;
    assign overrun   = ovr_q;
    assign busy      = (state_q != S_IDLE);
`ifdef UART_RX_PARITY_EN
    assign parity_err = perr_q;
`endif

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver: edge-accurate frames driven on rx, outputs sampled 1ns after each edge.
module tb_uart_receiver;

    localparam int C  = 16;
    localparam int DB = 8;
    localparam int H  = (C - 1) / 2;
`ifdef UART_RX_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif
    localparam int STOP_REL = 3 + H + (DB + 1 + PB) * C;
    localparam int NBITS    = DB + 2 + PB;

    logic          clk = 1'b0;
    logic          rst_n, rx, ready;
    logic [DB-1:0] data;
    logic          valid, frame_err, overrun, busy;
`ifdef UART_RX_PARITY_EN
    logic          parity_err;
`endif

    always #5 clk = ~clk;

    uart_receiver #(.CLKS_PER_BIT(C), .DATA_BITS(DB)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx        (rx),
        .data      (data),
        .valid     (valid),
        .ready     (ready),
        .frame_err (frame_err),
        .overrun   (overrun),
        .busy      (busy)
`ifdef UART_RX_PARITY_EN
        ,
        .parity_err(parity_err)
`endif
    );

    int nchk = 0, nerr = 0;
    int cyc = 0, e0 = 0;
    int vcnt, vfirst, fecnt, fe_rel, ovcnt, ov_rel, pecnt, bfirst, blast;
    int both_tot = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock edge, then record what the outputs show relative to E0.
    task automatic tick();
        int rel;
        @(posedge clk);
        #1;
        cyc++;
        rel = cyc - e0;
        if (valid === 1'b1) begin
            vcnt++;
            if (vfirst < 0) vfirst = rel;
        end
        if (frame_err === 1'b1) begin
            fecnt++;
            fe_rel = rel;
        end
        if (overrun === 1'b1) begin
            ovcnt++;
            ov_rel = rel;
        end
`ifdef UART_RX_PARITY_EN
        if (parity_err === 1'b1) pecnt++;
`endif
        if (frame_err === 1'b1 && overrun === 1'b1) both_tot++;
        if (busy === 1'b1) begin
            if (bfirst < 0) bfirst = rel;
            blast = rel;
        end
    endtask

    task automatic mon_clr();
        e0 = cyc + 1;
        vcnt = 0; vfirst = -1; fecnt = 0; fe_rel = -1;
        ovcnt = 0; ov_rel = -1; pecnt = 0; bfirst = -1; blast = -1;
    endtask

    // Drives the first nb bits of a frame; the first bit is captured at E0.
    task automatic send(input logic [DB-1:0] b, input logic stop_bit, input logic par_flip, input int nb);
        logic [NBITS-1:0] f;
        f[0] = 1'b0;
        for (int i = 0; i < DB; i++) f[1+i] = b[i];
        f[DB+1]     = (^b) ^ par_flip;
        f[NBITS-1]  = stop_bit;
        mon_clr();
        for (int j = 0; j < nb; j++) begin
            rx = f[j];
            repeat (C) tick();
        end
    endtask

    initial begin
        rst_n = 1'b0; rx = 1'b0; ready = 1'b0;
        mon_clr();
        repeat (3) tick();
        rst_n = 1'b1; rx = 1'b1;
        mon_clr();
        repeat (50) tick();
        chk("rst_data", data, 0);
        chk("rst_valid", valid, 0);
        chk("rst_busy", bfirst, -1);
        chk("rst_pulses", vcnt + fecnt + ovcnt + pecnt, 0);

        // good frame, consumer always ready
        ready = 1'b1;
        send(8'hA5, 1'b1, 1'b0, NBITS);
        rx = 1'b1; repeat (10) tick();
        chk("a5_valid_at", vfirst, STOP_REL);
        chk("a5_valid_len", vcnt, 1);
        chk("a5_data", data, 8'hA5);
        chk("a5_busy_first", bfirst, 2);
        chk("a5_busy_last", blast, STOP_REL - 1);
        chk("a5_no_ferr", fecnt, 0);

        // start glitch: 4 low cycles
        mon_clr();
        rx = 1'b0; repeat (4) tick();
        rx = 1'b1; repeat (20) tick();
        chk("glitch_busy_first", bfirst, 2);
        chk("glitch_busy_last", blast, 9);
        chk("glitch_no_valid", vcnt, 0);
        chk("glitch_no_ferr", fecnt, 0);

        // bad stop bit then held-low line
        send(8'h3C, 1'b0, 1'b0, NBITS);
        repeat (40) tick();
        chk("ferr_at", fe_rel, STOP_REL);
        chk("ferr_len", fecnt, 1);
        chk("ferr_no_valid", vcnt, 0);
        chk("ferr_busy_held", busy, 1);
        chk("ferr_data_kept", data, 8'hA5);
        rx = 1'b1; repeat (5) tick();
        chk("break_exit_busy", busy, 0);
        chk("break_ferr_len", fecnt, 1);
        send(8'h55, 1'b1, 1'b0, NBITS);
        rx = 1'b1; repeat (10) tick();
        chk("after_break_data", data, 8'h55);
        chk("after_break_valid", vcnt, 1);
        chk("after_break_ferr", fecnt, 0);

        // overrun with stalled consumer
        ready = 1'b0;
        send(8'h11, 1'b1, 1'b0, NBITS);
        rx = 1'b1; repeat (5) tick();
        chk("ov1_data", data, 8'h11);
        chk("ov1_valid", valid, 1);
        chk("ov1_no_ovr", ovcnt, 0);
        send(8'h22, 1'b1, 1'b0, NBITS);
        rx = 1'b1; repeat (5) tick();
        chk("ov2_at", ov_rel, STOP_REL);
        chk("ov2_len", ovcnt, 1);
        chk("ov2_data_kept", data, 8'h11);
        chk("ov2_valid", valid, 1);
        ready = 1'b1;
        tick();
        chk("consume_valid", valid, 0);
        chk("consume_data", data, 8'h11);

        // reset in the middle of data bit 3
        send(8'h7E, 1'b1, 1'b0, 4);
        rx = 1'b1; rst_n = 1'b0;
        repeat (2) tick();
        chk("midrst_busy", busy, 0);
        chk("midrst_data", data, 0);
        chk("midrst_valid", valid, 0);
        rst_n = 1'b1;
        repeat (20) tick();
        send(8'h7E, 1'b1, 1'b0, NBITS);
        rx = 1'b1; repeat (10) tick();
        chk("after_rst_data", data, 8'h7E);
        chk("after_rst_valid_at", vfirst, STOP_REL);

`ifdef UART_RX_PARITY_EN
        send(8'h07, 1'b1, 1'b0, NBITS);
        rx = 1'b1; repeat (10) tick();
        chk("par_ok_valid_at", vfirst, STOP_REL);
        chk("par_ok_data", data, 8'h07);
        chk("par_ok_no_perr", pecnt, 0);
        send(8'h07, 1'b1, 1'b1, NBITS);
        rx = 1'b1; repeat (10) tick();
        chk("par_bad_perr", pecnt, 1);
        chk("par_bad_no_valid", vcnt, 0);
        chk("par_bad_no_ferr", fecnt, 0);
`endif

        chk("ferr_ovr_exclusive", both_tot, 0);
        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule
